// File: rtl/stream_deserializer_if.sv
// Handshake bundle for the stream deserializer: narrow input beat stream and
// wide packed output word stream.
interface stream_deserializer_if #(
  parameter int DataBits = 8,
  parameter int Ratio    = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DataBits-1:0]       in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [Ratio*DataBits-1:0] out_data;
  logic [Ratio-1:0]          out_keep;
  logic                      out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/stream_deserializer.sv
// Packs Ratio narrow beats into one little-endian wide word; in_last closes a
// word early and tags it as last. Output stage is a single registered slot.
module stream_deserializer #(
  parameter int DataBits = 8,
  parameter int Ratio    = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  stream_deserializer_if.slave bus
);
  localparam int WordBits = Ratio * DataBits;
  localparam logic [Ratio-1:0] CntFirst = {{(Ratio-1){1'b0}}, 1'b1};

  logic [Ratio-1:0]              cnt_r;
  logic [(Ratio-1)*DataBits-1:0] acc_r;
  logic                          out_valid_r;
  logic [WordBits-1:0]           out_data_r;
  logic [Ratio-1:0]              out_keep_r;
  logic                          out_last_r;

  logic                in_ready_s;
  logic                accept_s;
  logic                close_s;
  logic [Ratio-1:0]    keep_s;
  logic [WordBits-1:0] acc_ext_s;
  logic [WordBits-1:0] word_s;

  assign in_ready_s = ~out_valid_r | bus.out_ready;
  assign accept_s   = bus.in_valid & in_ready_s;
  assign close_s    = accept_s & (cnt_r[Ratio-1] | bus.in_last);
  // cnt_r is one-hot, so subtracting one fills every slot below it
  assign keep_s     = cnt_r | (cnt_r - CntFirst);
  assign acc_ext_s  = {{DataBits{1'b0}}, acc_r};

  // Assemble the closing word: stored slots below cnt, the live beat at cnt, zeros above
  always_comb begin
    word_s = {WordBits{1'b0}};
    for (int k = 0; k < Ratio; k++) begin
      if (cnt_r[k]) begin
        word_s[k*DataBits +: DataBits] = bus.in_data;
      end else if (keep_s[k]) begin
        word_s[k*DataBits +: DataBits] = acc_ext_s[k*DataBits +: DataBits];
      end else begin
        word_s[k*DataBits +: DataBits] = {DataBits{1'b0}};
      end
    end
  end

  // Slot counter: advance on every non-closing beat, rewind on a closing beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CntFirst;
    end else if (close_s) begin
      cnt_r <= CntFirst;
    end else if (accept_s) begin
      cnt_r <= cnt_r << 1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Accumulator holds elements 0..Ratio-2 until the word closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {((Ratio-1)*DataBits){1'b0}};
    end else if (accept_s && !close_s) begin
      for (int k = 0; k < Ratio-1; k++) begin
        if (cnt_r[k]) begin
          acc_r[k*DataBits +: DataBits] <= bus.in_data;
        end
      end
    end else begin
      acc_r <= acc_r;
    end
  end

  // Output word register; a drain and a fresh load in the same cycle keep valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WordBits{1'b0}};
      out_keep_r  <= {Ratio{1'b0}};
      out_last_r  <= 1'b0;
    end else if (close_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= word_s;
      out_keep_r  <= keep_s;
      out_last_r  <= bus.in_last;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_keep  = out_keep_r;
  assign bus.out_last  = out_last_r;
endmodule

// File: tb/tb_stream_deserializer.sv
// Directed checks on a Ratio=4 deserializer plus randomised valid/ready runs on
// Ratio=2 and Ratio=3 instances against a packing scoreboard.
module tb_stream_deserializer;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  stream_deserializer_if #(.DataBits(8), .Ratio(4)) if4 ();
  stream_deserializer_if #(.DataBits(8), .Ratio(2)) if2 ();
  stream_deserializer_if #(.DataBits(8), .Ratio(3)) if3 ();

  stream_deserializer #(.DataBits(8), .Ratio(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  stream_deserializer #(.DataBits(8), .Ratio(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  stream_deserializer #(.DataBits(8), .Ratio(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  // index 0 drives the Ratio=2 instance, index 1 the Ratio=3 instance
  logic        iv[2];
  logic        il[2];
  logic        ordy[2];
  logic [7:0]  idat[2];
  logic        ov[2];
  logic        ir[2];
  logic        ol[2];
  logic [23:0] od[2];
  logic [2:0]  okp[2];

  assign if2.in_valid  = iv[0];
  assign if2.in_data   = idat[0];
  assign if2.in_last   = il[0];
  assign if2.out_ready = ordy[0];
  assign if3.in_valid  = iv[1];
  assign if3.in_data   = idat[1];
  assign if3.in_last   = il[1];
  assign if3.out_ready = ordy[1];
  assign ov[0]  = if2.out_valid;
  assign ov[1]  = if3.out_valid;
  assign ir[0]  = if2.in_ready;
  assign ir[1]  = if3.in_ready;
  assign ol[0]  = if2.out_last;
  assign ol[1]  = if3.out_last;
  assign od[0]  = {8'h00, if2.out_data};
  assign od[1]  = if3.out_data;
  assign okp[0] = {1'b0, if2.out_keep};
  assign okp[1] = if3.out_keep;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one beat on the Ratio=4 instance and return #1 after the edge that takes it
  task automatic beat(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    if4.in_valid = 1'b1;
    if4.in_data  = d;
    if4.in_last  = l;
    #1;
    while (!if4.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!if4.in_ready) check("accept_wait", 64'(if4.in_ready), 64'd1);
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    if4.in_last  = 1'b0;
  endtask

  task automatic word4(input string tag, input logic v, input logic [31:0] d,
                       input logic [3:0] k, input logic l);
    check({tag, "_valid"}, 64'(if4.out_valid), 64'(v));
    check({tag, "_data"},  64'(if4.out_data),  64'(d));
    check({tag, "_keep"},  64'(if4.out_keep),  64'(k));
    check({tag, "_last"},  64'(if4.out_last),  64'(l));
  endtask

  // Asynchronous reset pulse placed mid-cycle, outputs checked before any clock edge
  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    word4(tag, 1'b0, 32'h0, 4'h0, 1'b0);
    check({tag, "_in_ready"}, 64'(if4.in_ready), 64'd1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Scoreboard for the random runs: {last, keep[2:0], data[23:0]}
  logic [27:0] q0[$];
  logic [27:0] q1[$];
  logic [23:0] part[2];
  logic [2:0]  kp[2];
  int          pos[2];

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic random_run(input int cycles);
    logic [27:0] exp_w;
    for (int d = 0; d < 2; d++) begin
      part[d] = 24'h0;
      kp[d]   = 3'b000;
      pos[d]  = 0;
    end
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        iv[d]   = (c < cycles - 40) ? ($urandom_range(0, 3) != 0) : 1'b0;
        il[d]   = ($urandom_range(0, 4) == 0);
        idat[d] = 8'($urandom_range(0, 255));
        ordy[d] = (c < cycles - 40) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        if (ov[d] && ordy[d]) begin
          if (qsize(d) == 0) begin
            check((d == 0) ? "r2_spurious" : "r3_spurious", 64'(qsize(d)), 64'd1);
          end else begin
            exp_w = (d == 0) ? q0.pop_front() : q1.pop_front();
            check((d == 0) ? "r2_word" : "r3_word", {36'h0, ol[d], okp[d], od[d]}, 64'(exp_w));
          end
        end
        if (iv[d] && ir[d]) begin
          part[d][pos[d]*8 +: 8] = idat[d];
          kp[d][pos[d]] = 1'b1;
          if (pos[d] == d + 1 || il[d]) begin
            if (d == 0) q0.push_back({il[d], kp[d], part[d]});
            else        q1.push_back({il[d], kp[d], part[d]});
            part[d] = 24'h0;
            kp[d]   = 3'b000;
            pos[d]  = 0;
          end else begin
            pos[d]++;
          end
        end
      end
    end
    check("r2_drained", 64'(qsize(0)), 64'd0);
    check("r3_drained", 64'(qsize(1)), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    if4.in_valid = 1'b0; if4.in_data = 8'h00; if4.in_last = 1'b0; if4.out_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; il[d] = 1'b0; idat[d] = 8'h00; ordy[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    word4("reset", 1'b0, 32'h0, 4'h0, 1'b0);
    check("reset_in_ready", 64'(if4.in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Full words back-to-back, word valid the cycle after its fourth beat
    if4.out_ready = 1'b1;
    beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0);
    check("full_early_valid", 64'(if4.out_valid), 64'd0);
    beat(8'h04, 1'b0);
    word4("full1", 1'b1, 32'h04030201, 4'hF, 1'b0);
    beat(8'h05, 1'b0);
    check("full1_drained", 64'(if4.out_valid), 64'd0);
    beat(8'h06, 1'b0); beat(8'h07, 1'b0); beat(8'h08, 1'b0);
    word4("full2", 1'b1, 32'h08070605, 4'hF, 1'b0);

    // Partial word closed by in_last, then in_last on slot 0
    beat(8'h0A, 1'b0);
    beat(8'h0B, 1'b1);
    word4("partial", 1'b1, 32'h00000B0A, 4'h3, 1'b1);
    beat(8'h0C, 1'b1);
    word4("slot0_last", 1'b1, 32'h0000000C, 4'h1, 1'b1);
    @(posedge clk); #1;
    check("partial_drained", 64'(if4.out_valid), 64'd0);

    // Backpressure: stalled word stays put and blocks input
    if4.out_ready = 1'b0;
    beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);
    word4("bp_word1", 1'b1, 32'h04030201, 4'hF, 1'b0);
    if4.in_valid = 1'b1;
    if4.in_data  = 8'h05;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", 64'(if4.in_ready), 64'd0);
      word4("bp_hold", 1'b1, 32'h04030201, 4'hF, 1'b0);
    end
    if4.out_ready = 1'b1;
    beat(8'h05, 1'b0);
    check("bp_released", 64'(if4.out_valid), 64'd0);
    beat(8'h06, 1'b0); beat(8'h07, 1'b0); beat(8'h08, 1'b0);
    word4("bp_word2", 1'b1, 32'h08070605, 4'hF, 1'b0);

    // Pending word drained on the same edge a new closing beat loads
    beat(8'h0D, 1'b1);
    word4("simul", 1'b1, 32'h0000000D, 4'h1, 1'b1);

    // Async reset with a word pending, then reset in the middle of a word
    reset_pulse("rst_pending");
    beat(8'h11, 1'b0); beat(8'h22, 1'b0);
    reset_pulse("rst_midword");
    beat(8'h33, 1'b0); beat(8'h44, 1'b0); beat(8'h55, 1'b0); beat(8'h66, 1'b0);
    word4("after_rst", 1'b1, 32'h66554433, 4'hF, 1'b0);

    // Random valid/ready on the Ratio=2 and Ratio=3 instances
    random_run(600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
